unix_counter: RTL and testbench
===============================

// Module: unix_counter
// PURPOSE
//  Free-running 64-bit Unix-epoch seconds counter for the digital clock datapath.
//  A prescaler divides the system clock down to a 1 s tick, and each tick increments
//  the seconds count. The count can be paused, or loaded from a 64-bit preset
//  (time-set path). Downstream date/time decoders consume counter and tick.
// PARAMETERS
//  TICKS_PER_SEC  100_000_000  clk cycles per second; legal range >= 1
//  CNT_W          64           width of seconds counter and preset
// PORTS
//  clk         in   1      system clock; all state updates on its rising edge
//  reset_n     in   1      asynchronous, active-HIGH reset (asserted when 1, despite the suffix)
//  load_n      in   1      synchronous load strobe, active low
//  setCounter  in   CNT_W  preset value captured when load_n==0
//  go          in   1      count enable; 1 = run, 0 = pause
//  counter     out  CNT_W  current seconds count (registered)
//  tick        out  1      one-cycle pulse, high in the cycle counter shows the incremented value
// BEHAVIOUR
//  - Reset: while reset_n==1, immediately and independent of clk: counter=0,
//    prescaler=0, tick=0. State holds until the first clk edge after reset_n falls.
//  - Prescaler: internal, $clog2(TICKS_PER_SEC) bits (min 1), range 0..TICKS_PER_SEC-1.
//  - Priority per rising edge (reset deasserted): load > count > hold.
//  - Load (load_n==0): counter<=setCounter; prescaler<=0; tick<=0; go is ignored.
//    Holding load_n low for several cycles tracks setCounter each cycle.
//    The first possible increment after a load is TICKS_PER_SEC enabled cycles later.
//  - Count (load_n==1, go==1): if prescaler==TICKS_PER_SEC-1, then prescaler<=0,
//    counter<=counter+1, tick<=1. Otherwise prescaler<=prescaler+1, tick<=0.
//  - Hold (load_n==1, go==0): counter and prescaler frozen; tick<=0.
//    Resuming go continues the partial second; there is no phase loss.
//  - Wrap: counter 2^CNT_W-1 +1 -> 0, with tick asserted on the wrap cycle. No overflow flag.
//  - TICKS_PER_SEC==1: counter increments on every enabled cycle; tick stays high while go==1.
//  - Latency: load visible on counter 1 cycle after the sampling edge. Increment and tick
//    appear together, registered, at the edge where the prescaler terminal count is reached.
//  - Reset asserted mid-second discards the partial prescaler count.
//  - No combinational path from inputs to outputs.
// TESTING (bench uses TICKS_PER_SEC=4, 20 ns clk)
//  1. reset_n=1 for 5 cycles with go=1, setCounter=3 -> counter==0, tick==0 throughout.
//  2. Release reset, go=1, load_n=1 -> counter 0->1 after 4 cycles, then +1 every 4 cycles;
//     tick high exactly 1 cycle per increment.
//  3. Load: load_n=0 for 1 cycle with setCounter=3 -> counter==3 next cycle; ==4 four cycles
//     after load_n returns to 1.
//  4. Pause: drop go 2 cycles into a second for 10 cycles -> counter and tick frozen/low;
//     re-raise go -> increment after 2 more cycles.
//  5. Wrap: load 64'hFFFF_FFFF_FFFF_FFFF, go=1 -> after 4 cycles counter==0 and tick==1.
//  6. Async reset mid-count: assert reset_n between edges -> counter==0 before the next edge.
//     Load and go both active -> load wins.

Source files
------------

// File: rtl/unix_counter.sv
// Unix-epoch seconds counter: a prescaler divides clk down to a 1 s tick, and each
// tick advances a CNT_W-bit seconds count that can be paused or preset.
module unix_counter #(
    parameter int unsigned TICKS_PER_SEC = 100_000_000,
    parameter int unsigned CNT_W         = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_n,
    input  logic [CNT_W-1:0] setCounter,
    input  logic             go,
    output logic [CNT_W-1:0] counter,
    output logic             tick
);

    // A prescaler is at least one bit wide, even when every cycle is a full second.
    localparam int unsigned PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] counter_q, counter_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick_q, tick_d;

    // Next-state: load beats count, count beats hold.
    always_comb begin
        counter_d = counter_q;
        pre_d     = pre_q;
        tick_d    = 1'b0;
        if (!load_n) begin
            counter_d = setCounter;
            pre_d     = '0;
        end else if (go) begin
            if (pre_q == PRE_LAST) begin
                pre_d     = '0;
                counter_d = counter_q + CNT_W'(1);
                tick_d    = 1'b1;
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    // reset_n is active-high despite its name.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            counter_q <= '0;
            pre_q     <= '0;
            tick_q    <= 1'b0;
        end else begin
            counter_q <= counter_d;
            pre_q     <= pre_d;
            tick_q    <= tick_d;
        end
    end

    assign counter = counter_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_unix_counter.sv
// Randomized self-checking bench for unix_counter; reference model counts enabled
// cycles since the last load/reset and derives seconds and tick arithmetically.
module tb_unix_counter;

    localparam int unsigned TPS   = 4;
    localparam int unsigned CNT_W = 64;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             load_n;
    logic [CNT_W-1:0] setCounter;
    logic             go;
    logic [CNT_W-1:0] counter;
    logic             tick;

    int checks = 0;
    int errors = 0;

    // Model: seconds = base + (enabled cycles since base was set) / TPS.
    logic [CNT_W-1:0] m_base;
    longint unsigned  m_n;
    logic             m_tick;

    unix_counter #(.TICKS_PER_SEC(TPS), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_n     (load_n),
        .setCounter (setCounter),
        .go         (go),
        .counter    (counter),
        .tick       (tick)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [CNT_W-1:0] m_count();
        return m_base + CNT_W'(m_n / TPS);
    endfunction

    task automatic model_reset();
        m_base = '0;
        m_n    = 0;
        m_tick = 1'b0;
    endtask

    // One clock: advance the model with the inputs sampled at the edge, then compare.
    task automatic step(input string tag);
        @(posedge clk);
        if (reset_n) begin
            model_reset();
        end else if (!load_n) begin
            m_base = setCounter;
            m_n    = 0;
            m_tick = 1'b0;
        end else if (go) begin
            m_n++;
            m_tick = ((m_n % TPS) == 0);
        end else begin
            m_tick = 1'b0;
        end
        #1;
        check({tag, "_cnt"}, counter, m_count());
        check({tag, "_tick"}, 64'(tick), 64'(m_tick));
    endtask

    // Reset pulse placed between edges; outputs must clear before the next edge.
    task automatic async_reset_pulse(input string tag);
        #4 reset_n = 1'b1;
        #1;
        model_reset();
        check({tag, "_cnt"}, counter, 64'd0);
        check({tag, "_tick"}, 64'(tick), 64'd0);
        #2 reset_n = 1'b0;
    endtask

    initial begin
        logic [CNT_W-1:0] held;
        reset_n    = 1'b1;
        load_n     = 1'b1;
        go         = 1'b1;
        setCounter = 64'd3;
        model_reset();

        for (int i = 0; i < 5; i++) step("rst");

        reset_n = 1'b0;
        for (int i = 0; i < 20; i++) step("run");
        check("run_fixed", counter, 64'd5);

        load_n = 1'b0;
        setCounter = 64'd3;
        step("load");
        check("load_fixed", counter, 64'd3);
        load_n = 1'b1;
        for (int i = 0; i < 4; i++) step("post_load");
        check("post_load_fixed", counter, 64'd4);

        for (int i = 0; i < 2; i++) step("pre_pause");
        go = 1'b0;
        held = counter;
        for (int i = 0; i < 10; i++) step("pause");
        check("pause_fixed", counter, held);
        go = 1'b1;
        step("resume");
        check("resume_no_inc", counter, held);
        step("resume");
        check("resume_inc", counter, held + 64'd1);
        check("resume_tick", 64'(tick), 64'd1);

        load_n = 1'b0;
        setCounter = '1;
        step("wrap_load");
        load_n = 1'b1;
        for (int i = 0; i < 4; i++) step("wrap");
        check("wrap_fixed_cnt", counter, 64'd0);
        check("wrap_fixed_tick", 64'(tick), 64'd1);

        for (int i = 0; i < 3; i++) step("pre_areset");
        async_reset_pulse("areset");
        for (int i = 0; i < 5; i++) step("post_areset");

        load_n = 1'b0;
        go = 1'b1;
        setCounter = 64'h0123_4567_89AB_CDEF;
        step("load_vs_go");
        check("load_wins", counter, 64'h0123_4567_89AB_CDEF);
        load_n = 1'b0;
        setCounter = 64'h42;
        step("load_track");
        load_n = 1'b1;

        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 63));
            load_n = (r < 4) ? 1'b0 : 1'b1;
            go = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 0)
                setCounter = '1 - CNT_W'($urandom_range(0, 6));
            else
                setCounter = {$urandom, $urandom};
            if (r == 63) async_reset_pulse("rand_areset");
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
